// File: rtl/drum_acc_stage.sv
// drum_acc_stage: accumulates a stream of unsigned DRUM products into a wide
// saturating sum. A finished packet result (sum, term count, overflow flag) is
// presented on a valid/ready output handshake.
module drum_acc_stage #(
   parameter int  N         = 16,
   parameter int  ACC_W     = 40,
   parameter int  MAX_TERMS = 256,
   localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*N-1:0]     prod_data,
   input  logic               prod_valid,
   input  logic               prod_last,
   output logic               prod_ready,
   output logic [ACC_W-1:0]   acc_data,
   output logic [CNT_W-1:0]   acc_count,
   output logic               acc_ovf,
   output logic               acc_valid,
   input  logic               acc_ready
);

   localparam int SUM_W = ACC_W + 1;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t             state_reg;
   logic [ACC_W-1:0]   acc_data_reg;
   logic [CNT_W-1:0]   acc_count_reg;
   logic               acc_ovf_reg;
   logic               acc_valid_reg;

   logic [SUM_W-1:0]   sum_ext;
   logic [CNT_W-1:0]   count_inc;
   logic               term_limit;
   logic               prod_accept;
   logic               packet_end;

   // One guard bit above the accumulator exposes the carry used for saturation.
   assign sum_ext     = {1'b0, acc_data_reg} + SUM_W'(prod_data);
   assign count_inc   = acc_count_reg + CNT_W'(1);
   assign term_limit  = (count_inc == CNT_W'(MAX_TERMS));

   // Ready is held low during reset so no beat can slip in on the reset edge.
   assign prod_ready  = (state_reg == ACCUM) && !rst;
   assign prod_accept = prod_valid && prod_ready;

   // A packet closes on an explicit last or when the term limit is reached.
   assign packet_end  = prod_last || term_limit;

   // Two-state packet FSM: ACCUM sums accepted beats, DONE holds the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ACCUM;
         acc_data_reg  <= '0;
         acc_count_reg <= '0;
         acc_ovf_reg   <= 1'b0;
         acc_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (prod_accept) begin
                  // Saturation is sticky: once overflowed, stay at all-ones.
                  if (sum_ext[ACC_W] || acc_ovf_reg) begin
                     acc_data_reg <= '1;
                     acc_ovf_reg  <= 1'b1;
                  end else begin
                     acc_data_reg <= sum_ext[ACC_W-1:0];
                  end
                  acc_count_reg <= count_inc;
                  if (packet_end) begin
                     state_reg     <= DONE;
                     acc_valid_reg <= 1'b1;
                  end
               end
            end
            DONE: begin
               // Result retired: clear for the next packet, no bypass of input.
               if (acc_ready) begin
                  state_reg     <= ACCUM;
                  acc_data_reg  <= '0;
                  acc_count_reg <= '0;
                  acc_ovf_reg   <= 1'b0;
                  acc_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= ACCUM;
               acc_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign acc_data  = acc_data_reg;
   assign acc_count = acc_count_reg;
   assign acc_ovf   = acc_ovf_reg;
   assign acc_valid = acc_valid_reg;

endmodule

// File: tb/tb_drum_acc_stage.sv
// tb_drum_acc_stage: three parameterisations of the accumulator (defaults,
// narrow accumulator, small term limit) share one stimulus path selected by
// 'sel'. Expected packet results go into a queue when a packet is driven and
// are compared when the result handshake occurs.
module tb_drum_acc_stage;

   logic        clk;
   logic        rst;
   logic [31:0] prod_data;
   logic        prod_valid;
   logic        prod_last;
   logic        acc_ready;
   int          sel;

   // instance 0: defaults
   logic        pv0, ar0, pr0, av0, ov0;
   logic [39:0] ad0;
   logic [8:0]  ac0;
   // instance 1: ACC_W = 34
   logic        pv1, ar1, pr1, av1, ov1;
   logic [33:0] ad1;
   logic [8:0]  ac1;
   // instance 2: MAX_TERMS = 4
   logic        pv2, ar2, pr2, av2, ov2;
   logic [39:0] ad2;
   logic [2:0]  ac2;

   logic        prod_ready_m, acc_valid_m, acc_ovf_m;
   logic [39:0] acc_data_m;
   logic [8:0]  acc_count_m;

   assign pv0 = prod_valid && (sel == 0);
   assign pv1 = prod_valid && (sel == 1);
   assign pv2 = prod_valid && (sel == 2);
   assign ar0 = acc_ready && (sel == 0);
   assign ar1 = acc_ready && (sel == 1);
   assign ar2 = acc_ready && (sel == 2);

   drum_acc_stage u_dut0 (
      .clk(clk), .rst(rst), .prod_data(prod_data), .prod_valid(pv0),
      .prod_last(prod_last), .prod_ready(pr0), .acc_data(ad0),
      .acc_count(ac0), .acc_ovf(ov0), .acc_valid(av0), .acc_ready(ar0)
   );

   drum_acc_stage #(.ACC_W(34)) u_dut1 (
      .clk(clk), .rst(rst), .prod_data(prod_data), .prod_valid(pv1),
      .prod_last(prod_last), .prod_ready(pr1), .acc_data(ad1),
      .acc_count(ac1), .acc_ovf(ov1), .acc_valid(av1), .acc_ready(ar1)
   );

   drum_acc_stage #(.MAX_TERMS(4)) u_dut2 (
      .clk(clk), .rst(rst), .prod_data(prod_data), .prod_valid(pv2),
      .prod_last(prod_last), .prod_ready(pr2), .acc_data(ad2),
      .acc_count(ac2), .acc_ovf(ov2), .acc_valid(av2), .acc_ready(ar2)
   );

   always_comb begin
      prod_ready_m = 1'b0;
      acc_valid_m  = 1'b0;
      acc_ovf_m    = 1'b0;
      acc_data_m   = '0;
      acc_count_m  = '0;
      case (sel)
         0: begin
            prod_ready_m = pr0; acc_valid_m = av0; acc_ovf_m = ov0;
            acc_data_m = ad0; acc_count_m = ac0;
         end
         1: begin
            prod_ready_m = pr1; acc_valid_m = av1; acc_ovf_m = ov1;
            acc_data_m = {6'b0, ad1}; acc_count_m = ac1;
         end
         2: begin
            prod_ready_m = pr2; acc_valid_m = av2; acc_ovf_m = ov2;
            acc_data_m = ad2; acc_count_m = {6'b0, ac2};
         end
         default: ;
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [39:0] data;
      logic [8:0]  count;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];

   task automatic push_exp(input logic [39:0] d, input logic [8:0] c, input logic o);
      exp_t e;
      e.data = d; e.count = c; e.ovf = o;
      exp_q.push_back(e);
   endtask

   // acc_ready only changes just after a rising edge, so the value seen here
   // is the one the next rising edge acts on.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && acc_valid_m && acc_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got data 0x%0h count %0d, required no result",
                     acc_data_m, acc_count_m);
         end else begin
            e = exp_q.pop_front();
            check("result_data",  64'(acc_data_m),  64'(e.data));
            check("result_count", 64'(acc_count_m), 64'(e.count));
            check("result_ovf",   64'(acc_ovf_m),   64'(e.ovf));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [31:0] d, input logic l, output int stalls);
      logic ok_now;
      logic accepted;
      accepted   = 1'b0;
      stalls     = 0;
      prod_data  = d;
      prod_last  = l;
      prod_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         ok_now = prod_ready_m;
         @(posedge clk);
         #1;
         if (ok_now) begin
            accepted = 1'b1;
            break;
         end
         stalls++;
      end
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      if (!accepted) check("send_timeout", 64'(accepted), 64'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 50; t++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- packet table ----------------
   typedef struct {
      int              sel;
      int              n;
      logic [4:0][31:0] d;
      int              last_idx;
      int              chk_idx;
      logic [39:0]     chk_val;
      logic [39:0]     ed;
      logic [8:0]      ec;
      logic            eo;
   } pkt_t;

   pkt_t tbl[7];

   task automatic set_pkt(input int i, input int s, input int n,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [31:0] d4, input int li, input int ci,
                          input logic [39:0] cv, input logic [39:0] ed,
                          input logic [8:0] ec, input logic eo);
      tbl[i].sel = s; tbl[i].n = n;
      tbl[i].d[0] = d0; tbl[i].d[1] = d1; tbl[i].d[2] = d2;
      tbl[i].d[3] = d3; tbl[i].d[4] = d4;
      tbl[i].last_idx = li; tbl[i].chk_idx = ci; tbl[i].chk_val = cv;
      tbl[i].ed = ed; tbl[i].ec = ec; tbl[i].eo = eo;
   endtask

   initial begin
      int st;
      set_pkt(0, 0, 3, 32'd6, 32'd100, 32'hFFFE0001, 0, 0, 2, -1, 40'd0,
              40'h00FFFE006B, 9'd3, 1'b0);
      set_pkt(1, 1, 5, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001,
              32'hFFFE0001, 4, 3, 40'h03FFF80004, 40'h03FFFFFFFF, 9'd5, 1'b1);
      set_pkt(2, 1, 1, 32'd2, 0, 0, 0, 0, 0, -1, 40'd0, 40'd2, 9'd1, 1'b0);
      set_pkt(3, 2, 4, 32'd1, 32'd1, 32'd1, 32'd1, 0, -1, -1, 40'd0,
              40'd4, 9'd4, 1'b0);
      set_pkt(4, 0, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 40'h00FFFFFFFF,
              40'h01FFFFFFFE, 9'd2, 1'b0);
      set_pkt(5, 2, 3, 32'd5, 32'd6, 32'd7, 0, 0, 2, -1, 40'd0, 40'd18, 9'd3, 1'b0);
      set_pkt(6, 0, 1, 32'd0, 0, 0, 0, 0, 0, -1, 40'd0, 40'd0, 9'd1, 1'b0);

      rst = 1'b1; prod_data = '0; prod_valid = 1'b0; prod_last = 1'b0;
      acc_ready = 1'b0; sel = 0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_prod_ready", 64'(prod_ready_m), 64'd0);
      check("rst_acc_valid",  64'(acc_valid_m),  64'd0);
      check("rst_acc_data",   64'(acc_data_m),   64'd0);
      check("rst_acc_count",  64'(acc_count_m),  64'd0);
      check("rst_acc_ovf",    64'(acc_ovf_m),    64'd0);
      rst = 1'b0;
      acc_ready = 1'b1;
      #1;
      check("idle_prod_ready", 64'(prod_ready_m), 64'd1);

      // table-driven packets
      for (int i = 0; i < 7; i++) begin
         sel = tbl[i].sel;
         push_exp(tbl[i].ed, tbl[i].ec, tbl[i].eo);
         for (int b = 0; b < tbl[i].n; b++) begin
            send(tbl[i].d[b], (b == tbl[i].last_idx), st);
            if (b == tbl[i].chk_idx)
               check($sformatf("pkt%0d_partial", i), 64'(acc_data_m), 64'(tbl[i].chk_val));
         end
         check($sformatf("pkt%0d_latency_valid", i), 64'(acc_valid_m), 64'd1);
         drain();
      end

      // backpressure: result held while a new beat waits upstream
      sel = 0;
      acc_ready = 1'b0;
      push_exp(40'h00FFFE006B, 9'd3, 1'b0);
      send(32'd6, 1'b0, st);
      send(32'd100, 1'b0, st);
      send(32'hFFFE0001, 1'b1, st);
      prod_data = 32'd7; prod_last = 1'b0; prod_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_prod_ready", 64'(prod_ready_m), 64'd0);
         check("bp_acc_valid",  64'(acc_valid_m),  64'd1);
         check("bp_acc_data",   64'(acc_data_m),   64'h00FFFE006B);
         check("bp_acc_count",  64'(acc_count_m),  64'd3);
      end
      @(posedge clk);
      #1;
      acc_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_after_prod_ready", 64'(prod_ready_m), 64'd1);
      check("bp_after_acc_valid",  64'(acc_valid_m),  64'd0);
      check("bp_after_acc_data",   64'(acc_data_m),   64'd0);
      @(posedge clk);
      #1;
      prod_valid = 1'b0;
      check("bp_new_data",  64'(acc_data_m),  64'd7);
      check("bp_new_count", 64'(acc_count_m), 64'd1);
      push_exp(40'd7, 9'd2, 1'b0);
      send(32'd0, 1'b1, st);
      drain();

      // forced termination with a stalled fifth beat
      sel = 2;
      acc_ready = 1'b0;
      push_exp(40'd4, 9'd4, 1'b0);
      for (int b = 0; b < 4; b++) send(32'd1, 1'b0, st);
      check("ft_valid", 64'(acc_valid_m), 64'd1);
      check("ft_data",  64'(acc_data_m),  64'd4);
      check("ft_count", 64'(acc_count_m), 64'd4);
      prod_data = 32'd1; prod_last = 1'b0; prod_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ft_stall_ready", 64'(prod_ready_m), 64'd0);
         check("ft_stall_count", 64'(acc_count_m),  64'd4);
      end
      @(posedge clk);
      #1;
      acc_ready = 1'b1;
      @(posedge clk);
      #1;
      check("ft_ret_ready", 64'(prod_ready_m), 64'd1);
      @(posedge clk);
      #1;
      prod_valid = 1'b0;
      check("ft_new_data",  64'(acc_data_m),  64'd1);
      check("ft_new_count", 64'(acc_count_m), 64'd1);
      check("ft_new_valid", 64'(acc_valid_m), 64'd0);
      push_exp(40'd1, 9'd2, 1'b0);
      send(32'd0, 1'b1, st);
      drain();

      // reset mid-packet discards partial state
      sel = 0;
      send(32'd10, 1'b0, st);
      send(32'd20, 1'b0, st);
      check("mr_partial", 64'(acc_data_m), 64'd30);
      rst = 1'b1;
      #1;
      check("mr_ready_in_rst", 64'(prod_ready_m), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("mr_data",  64'(acc_data_m),  64'd0);
      check("mr_count", 64'(acc_count_m), 64'd0);
      check("mr_valid", 64'(acc_valid_m), 64'd0);
      check("mr_ready", 64'(prod_ready_m), 64'd1);
      push_exp(40'd5, 9'd1, 1'b0);
      send(32'd5, 1'b1, st);
      drain();

      // back-to-back single-beat packets
      push_exp(40'd3, 9'd1, 1'b0);
      push_exp(40'd9, 9'd1, 1'b0);
      send(32'd3, 1'b1, st);
      check("b2b_valid", 64'(acc_valid_m), 64'd1);
      check("b2b_ready", 64'(prod_ready_m), 64'd0);
      send(32'd9, 1'b1, st);
      check("b2b_stalls", 64'(st), 64'd1);
      drain();

      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
